spi_engine_offload_seq: RTL and testbench
=========================================

Name: spi_engine_offload_seq

Overview:
- Offload sequencer that sits between the SPI engine register interface and the SPI execution engine.
- Stores a command program and an SDO data table, written through the interface's offload0_* control outputs.
- On each external trigger it replays both as cmd/sdo streams into the execution engine, with no CPU involvement.
- Routes the resulting SDI words to an AXI-Stream style sink; a transfer ends when the engine returns a sync.

Parameters:
CMD_MEM_ADDRESS_WIDTH, 4, log2 depth of command memory (16-bit entries)
SDO_MEM_ADDRESS_WIDTH, 4, log2 depth of SDO memory
DATA_WIDTH, 8, SDO/SDI word width
NUM_OF_SDI, 1, number of parallel SDI lanes; SDI bus width = NUM_OF_SDI*DATA_WIDTH

Ports:
clk  in  1  clock; all logic single-clock
rstn  in  1  reset, synchronous, active-low
ctrl_cmd_wr_en  in  1  append ctrl_cmd_wr_data to command memory
ctrl_cmd_wr_data  in  16  command word
ctrl_sdo_wr_en  in  1  append ctrl_sdo_wr_data to SDO memory
ctrl_sdo_wr_data  in  DATA_WIDTH  SDO word
ctrl_mem_reset  in  1  single-cycle pulse; clears both memory lengths
ctrl_enable  in  1  level; arm the sequencer
ctrl_enabled  out  1  sequencer active (state != DISABLED)
trigger  in  1  start request, sampled in WAIT_TRIG only
cmd_valid  out  1  command stream valid
cmd_ready  in  1  command stream ready
cmd_data  out  16  command word
sdo_data_valid  out  1  SDO stream valid
sdo_data_ready  in  1  SDO stream ready
sdo_data  out  DATA_WIDTH  SDO word
sdi_data_valid  in  1  SDI from engine
sdi_data_ready  out  1  SDI ready to engine
sdi_data  in  NUM_OF_SDI*DATA_WIDTH  SDI word
sync_valid  in  1  sync from engine
sync_ready  out  1  sync ready; constant 1
sync_data  in  8  sync id; not used by this block
offload_sdi_valid  out  1  SDI to sink
offload_sdi_ready  in  1  sink ready
offload_sdi_data  out  NUM_OF_SDI*DATA_WIDTH  SDI to sink

Behaviour:
- Reset: state DISABLED; cmd_len = 0; sdo_len = 0; read pointers 0; cmd_valid = 0; sdo_data_valid = 0; ctrl_enabled = 0.
- Memory writes:
  - Accepted only in DISABLED; ignored in all other states.
  - Each write stores at address len, then len increments.
  - len is W+1 bits and saturates at 2^W: writes beyond full are dropped, with no wrap and no overwrite.
- ctrl_mem_reset:
  - Honoured only in DISABLED; sets both lens to 0. Memory contents need not be cleared.
  - If a write and ctrl_mem_reset occur in the same cycle, the reset wins.
- Memory reads are asynchronous: cmd_data = cmd_mem[cmd_rd_ptr], sdo_data = sdo_mem[sdo_rd_ptr].
- State machine:
  - DISABLED -> WAIT_TRIG when ctrl_enable = 1.
  - WAIT_TRIG:
    - If ctrl_enable = 0, go to DISABLED.
    - Else if trigger = 1 and cmd_len != 0, go to SEND and clear both read pointers.
    - A trigger with cmd_len = 0 is ignored.
  - SEND:
    - cmd_valid = 1.
    - On cmd_valid & cmd_ready, cmd_rd_ptr increments.
    - On the handshake where cmd_rd_ptr = cmd_len-1, go to WAIT_SYNC; cmd_valid drops the next cycle.
  - WAIT_SYNC:
    - On sync_valid, go to WAIT_TRIG if ctrl_enable = 1, else DISABLED.
    - Syncs received in SEND are consumed and ignored.
- SDO stream:
  - sdo_data_valid = 1 in SEND or WAIT_SYNC while sdo_rd_ptr < sdo_len.
  - On handshake, sdo_rd_ptr increments.
  - SDO words left unconsumed at sync are discarded when the next transfer clears the pointer.
- ctrl_enable deasserted mid-transfer: the current transfer runs to its sync, then the sequencer enters DISABLED. ctrl_enabled stays 1 until then.
- Trigger asserted in SEND/WAIT_SYNC is ignored; it is not queued.
- SDI path is combinational pass-through:
  - offload_sdi_valid = sdi_data_valid.
  - offload_sdi_data = sdi_data.
  - sdi_data_ready = offload_sdi_ready.
- Latency: first cmd_valid occurs the cycle after trigger is sampled in WAIT_TRIG.

Test Plan:
- Program load:
  - Stimulus: in DISABLED write cmds 0x1001, 0x2002, 0x3003 and SDO 0xA5, 0x5A; enable; pulse trigger.
  - Required: cmd stream emits exactly 0x1001, 0x2002, 0x3003 and sdo emits 0xA5, 0x5A; cmd_valid drops after the third handshake.
- Backpressure:
  - Stimulus: hold cmd_ready low for 5 cycles mid-program.
  - Required: cmd_data held stable, no word skipped or duplicated, sdo stream unaffected.
- Repeat and ignore:
  - Stimulus: sync_valid after the last cmd, then a second trigger; separately, a trigger during SEND.
  - Required: the second trigger replays an identical sequence from index 0; the trigger during SEND produces no extra replay.
- Full and reset:
  - Stimulus: write 17 cmds (W = 4).
  - Required: cmd_len = 16 and the 17th write is dropped.
  - Stimulus: ctrl_mem_reset, then enable + trigger.
  - Required: no cmd_valid.
- Disable mid-transfer:
  - Stimulus: drop ctrl_enable during SEND.
  - Required: remaining cmds are still issued, ctrl_enabled = 1 until sync, then 0; memory writes are ignored until DISABLED.
- SDI pass-through and reset:
  - Stimulus: send sdi_data 0x3C with offload_sdi_ready toggling.
  - Required: sdi_data_ready mirrors offload_sdi_ready in the same cycle.
  - Stimulus: rstn low in SEND.
  - Required: the next cycle has cmd_valid = 0, ctrl_enabled = 0 and lens = 0.

Source files
------------

// File: rtl/spi_engine_offload_seq.sv
// spi_engine_offload_seq
//   Offload sequencer between the SPI engine register interface and the
//   execution engine. A command program and an SDO table are loaded while
//   disabled; each trigger replays both into the engine without CPU help.
//   SDI words are passed straight through to a stream sink.
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   ctrl_cmd_wr_en/_data           append a 16-bit word to the command memory
//   ctrl_sdo_wr_en/_data           append a DATA_WIDTH word to the SDO memory
//   ctrl_mem_reset                 clear both memory lengths (DISABLED only)
//   ctrl_enable / ctrl_enabled     arm request / sequencer-active status
//   trigger                        start a replay (sampled in WAIT_TRIG only)
//   cmd_*                          command stream to the engine
//   sdo_data_*                     SDO stream to the engine
//   sdi_data_*                     SDI stream from the engine
//   sync_*                         sync stream from the engine (always ready)
//   offload_sdi_*                  SDI stream to the sink
module spi_engine_offload_seq #(
    parameter int CMD_MEM_ADDRESS_WIDTH = 4,
    parameter int SDO_MEM_ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH            = 8,
    parameter int NUM_OF_SDI            = 1
) (
    input  logic                             clk,
    input  logic                             rstn,

    input  logic                             ctrl_cmd_wr_en,
    input  logic [15:0]                      ctrl_cmd_wr_data,
    input  logic                             ctrl_sdo_wr_en,
    input  logic [DATA_WIDTH-1:0]            ctrl_sdo_wr_data,
    input  logic                             ctrl_mem_reset,
    input  logic                             ctrl_enable,
    output logic                             ctrl_enabled,

    input  logic                             trigger,

    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [15:0]                      cmd_data,

    output logic                             sdo_data_valid,
    input  logic                             sdo_data_ready,
    output logic [DATA_WIDTH-1:0]            sdo_data,

    input  logic                             sdi_data_valid,
    output logic                             sdi_data_ready,
    input  logic [NUM_OF_SDI*DATA_WIDTH-1:0] sdi_data,

    input  logic                             sync_valid,
    output logic                             sync_ready,
    input  logic [7:0]                       sync_data,

    output logic                             offload_sdi_valid,
    input  logic                             offload_sdi_ready,
    output logic [NUM_OF_SDI*DATA_WIDTH-1:0] offload_sdi_data
);

    localparam int CW = CMD_MEM_ADDRESS_WIDTH;
    localparam int SW = SDO_MEM_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_WAIT_TRIG,
        ST_SEND,
        ST_WAIT_SYNC
    } state_t;

    state_t state_q, state_d;

    // Lengths are one bit wider than the address so "full" (2^W) is representable.
    logic [CW:0]   cmd_len_q, cmd_len_d;
    logic [SW:0]   sdo_len_q, sdo_len_d;
    logic [CW-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
    // SDO pointer must reach sdo_len to signal "table exhausted".
    logic [SW:0]   sdo_rd_ptr_q, sdo_rd_ptr_d;

    logic [15:0]           cmd_mem [2**CW];
    logic [DATA_WIDTH-1:0] sdo_mem [2**SW];

    logic cmd_wr, sdo_wr, cmd_last;
    logic sync_unused;

    // Writes only while disabled, dropped when full, and lose to a same-cycle memory reset.
    assign cmd_wr = (state_q == ST_DISABLED) && ctrl_cmd_wr_en && !ctrl_mem_reset && !cmd_len_q[CW];
    assign sdo_wr = (state_q == ST_DISABLED) && ctrl_sdo_wr_en && !ctrl_mem_reset && !sdo_len_q[SW];

    assign cmd_last = ({1'b0, cmd_rd_ptr_q} == cmd_len_q - (CW+1)'(1));

    // Outputs
    assign ctrl_enabled      = (state_q != ST_DISABLED);
    assign cmd_valid         = (state_q == ST_SEND);
    assign cmd_data          = cmd_mem[cmd_rd_ptr_q];
    assign sdo_data_valid    = ((state_q == ST_SEND) || (state_q == ST_WAIT_SYNC)) &&
                               (sdo_rd_ptr_q < sdo_len_q);
    assign sdo_data          = sdo_mem[sdo_rd_ptr_q[SW-1:0]];
    assign sync_ready        = 1'b1;
    assign offload_sdi_valid = sdi_data_valid;
    assign offload_sdi_data  = sdi_data;
    assign sdi_data_ready    = offload_sdi_ready;

    // Sync id carries no meaning for the sequencer.
    assign sync_unused = ^sync_data;

    always_ff @(posedge clk) begin
        if (cmd_wr) cmd_mem[cmd_len_q[CW-1:0]] <= ctrl_cmd_wr_data;
        if (sdo_wr) sdo_mem[sdo_len_q[SW-1:0]] <= ctrl_sdo_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_DISABLED;
            cmd_len_q    <= '0;
            sdo_len_q    <= '0;
            cmd_rd_ptr_q <= '0;
            sdo_rd_ptr_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_len_q    <= cmd_len_d;
            sdo_len_q    <= sdo_len_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            sdo_rd_ptr_q <= sdo_rd_ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_len_d    = cmd_len_q;
        sdo_len_d    = sdo_len_q;
        cmd_rd_ptr_d = cmd_rd_ptr_q;
        sdo_rd_ptr_d = sdo_rd_ptr_q;

        case (state_q)
            ST_DISABLED: begin
                if (ctrl_mem_reset) begin
                    cmd_len_d = '0;
                    sdo_len_d = '0;
                end else begin
                    if (cmd_wr) cmd_len_d = cmd_len_q + (CW+1)'(1);
                    if (sdo_wr) sdo_len_d = sdo_len_q + (SW+1)'(1);
                end
                if (ctrl_enable) state_d = ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
                if (!ctrl_enable) begin
                    state_d = ST_DISABLED;
                end else if (trigger && (cmd_len_q != '0)) begin
                    state_d      = ST_SEND;
                    cmd_rd_ptr_d = '0;
                    sdo_rd_ptr_d = '0;
                end
            end
            ST_SEND: begin
                // Syncs arriving here are accepted (sync_ready=1) and dropped.
                if (cmd_ready) begin
                    cmd_rd_ptr_d = cmd_rd_ptr_q + CW'(1);
                    if (cmd_last) state_d = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                if (sync_valid) state_d = ctrl_enable ? ST_WAIT_TRIG : ST_DISABLED;
            end
            default: state_d = ST_DISABLED;
        endcase

        if (sdo_data_valid && sdo_data_ready) sdo_rd_ptr_d = sdo_rd_ptr_q + (SW+1)'(1);
    end

endmodule

// File: tb/tb_spi_engine_offload_seq.sv
module tb_spi_engine_offload_seq;
    localparam int DW = 8;
    localparam int NS = 1;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ctrl_cmd_wr_en = 1'b0;
    logic [15:0]   ctrl_cmd_wr_data = '0;
    logic          ctrl_sdo_wr_en = 1'b0;
    logic [DW-1:0] ctrl_sdo_wr_data = '0;
    logic          ctrl_mem_reset = 1'b0;
    logic          ctrl_enable = 1'b0;
    logic          ctrl_enabled;
    logic          trigger = 1'b0;
    logic          cmd_valid, cmd_ready = 1'b0;
    logic [15:0]   cmd_data;
    logic          sdo_data_valid, sdo_data_ready = 1'b0;
    logic [DW-1:0] sdo_data;
    logic          sdi_data_valid = 1'b0, sdi_data_ready;
    logic [NS*DW-1:0] sdi_data = '0;
    logic          sync_valid = 1'b0, sync_ready;
    logic [7:0]    sync_data = 8'h00;
    logic          offload_sdi_valid, offload_sdi_ready = 1'b0;
    logic [NS*DW-1:0] offload_sdi_data;

    spi_engine_offload_seq dut (
        .clk(clk), .rstn(rstn),
        .ctrl_cmd_wr_en(ctrl_cmd_wr_en), .ctrl_cmd_wr_data(ctrl_cmd_wr_data),
        .ctrl_sdo_wr_en(ctrl_sdo_wr_en), .ctrl_sdo_wr_data(ctrl_sdo_wr_data),
        .ctrl_mem_reset(ctrl_mem_reset), .ctrl_enable(ctrl_enable), .ctrl_enabled(ctrl_enabled),
        .trigger(trigger),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .sdo_data_valid(sdo_data_valid), .sdo_data_ready(sdo_data_ready), .sdo_data(sdo_data),
        .sdi_data_valid(sdi_data_valid), .sdi_data_ready(sdi_data_ready), .sdi_data(sdi_data),
        .sync_valid(sync_valid), .sync_ready(sync_ready), .sync_data(sync_data),
        .offload_sdi_valid(offload_sdi_valid), .offload_sdi_ready(offload_sdi_ready),
        .offload_sdi_data(offload_sdi_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the stored program, whether the sequencer is idle-disabled,
    // and the scoreboard of words each stream still owes.
    logic [15:0]      cmd_prog[$];
    logic [DW-1:0]    sdo_prog[$];
    logic [15:0]      cmd_exp[$];
    logic [DW-1:0]    sdo_exp[$];
    logic [NS*DW-1:0] sdi_exp[$];
    bit m_dis = 1'b1;
    bit cmd_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h expected=no-word t=%0t", name, act, $time);
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_exp.size() == 0) extra("cmd_extra", 32'(cmd_data));
                else chk("cmd_word", 32'(cmd_data), 32'(cmd_exp.pop_front()));
            end
            if (sdo_data_valid && sdo_data_ready) begin
                if (sdo_exp.size() == 0) extra("sdo_extra", 32'(sdo_data));
                else chk("sdo_word", 32'(sdo_data), 32'(sdo_exp.pop_front()));
            end
            if (offload_sdi_valid && offload_sdi_ready) begin
                if (sdi_exp.size() == 0) extra("sdi_extra", 32'(offload_sdi_data));
                else chk("sdi_word", 32'(offload_sdi_data), 32'(sdi_exp.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cmd_ready      = cmd_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        sdo_data_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic wr_cmd(input logic [15:0] v);
        ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_data = v;
        tick();
        ctrl_cmd_wr_en = 1'b0;
        if (m_dis && cmd_prog.size() < DEPTH) cmd_prog.push_back(v);
    endtask

    task automatic wr_sdo(input logic [DW-1:0] v);
        ctrl_sdo_wr_en = 1'b1; ctrl_sdo_wr_data = v;
        tick();
        ctrl_sdo_wr_en = 1'b0;
        if (m_dis && sdo_prog.size() < DEPTH) sdo_prog.push_back(v);
    endtask

    // Optionally collides a command write with the reset; the reset must win.
    task automatic mem_rst(input bit with_wr);
        ctrl_mem_reset = 1'b1;
        ctrl_cmd_wr_en = with_wr; ctrl_cmd_wr_data = 16'hBEEF;
        tick();
        ctrl_mem_reset = 1'b0; ctrl_cmd_wr_en = 1'b0;
        if (m_dis) begin cmd_prog.delete(); sdo_prog.delete(); end
    endtask

    task automatic set_en(input bit v);
        ctrl_enable = v;
        tick();
        m_dis = !v;
        chk("enable_level", 32'(ctrl_enabled), 32'(v));
    endtask

    task automatic trig();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        if (!m_dis && cmd_prog.size() != 0) begin
            foreach (cmd_prog[i]) cmd_exp.push_back(cmd_prog[i]);
            foreach (sdo_prog[i]) sdo_exp.push_back(sdo_prog[i]);
            chk("trig_latency", 32'(cmd_valid), 32'd1);
        end
    endtask

    // mode: 0 plain, 1 cmd backpressure, 2 trigger+sync during SEND, 3 disable+writes mid-transfer
    task automatic run_xfer(input int mode);
        int  n = 0;
        bit  done = 1'b0;
        while ((cmd_exp.size() != 0 || sdo_exp.size() != 0) && n < 500) begin
            if (!done && mode != 0 && cmd_exp.size() == 2) begin
                done = 1'b1;
                case (mode)
                    1: begin
                        cmd_hold = 1'b1; cmd_ready = 1'b0;
                        for (int i = 0; i < 5; i++) begin
                            chk("bp_valid", 32'(cmd_valid), 32'd1);
                            chk("bp_data", 32'(cmd_data), 32'(cmd_exp[0]));
                            tick();
                        end
                        chk("bp_no_skip", 32'(cmd_exp.size()), 32'd2);
                        cmd_hold = 1'b0;
                    end
                    2: begin
                        cmd_hold = 1'b1; cmd_ready = 1'b0;
                        trigger = 1'b1; sync_valid = 1'b1;
                        tick();
                        trigger = 1'b0; sync_valid = 1'b0; cmd_hold = 1'b0;
                        chk("sync_in_send", 32'(cmd_valid), 32'd1);
                    end
                    default: begin
                        ctrl_enable = 1'b0;
                        ctrl_cmd_wr_en = 1'b1; ctrl_cmd_wr_data = 16'hDEAD;
                        ctrl_sdo_wr_en = 1'b1; ctrl_sdo_wr_data = 8'hEE;
                        tick();
                        ctrl_cmd_wr_en = 1'b0; ctrl_sdo_wr_en = 1'b0;
                        chk("enabled_mid", 32'(ctrl_enabled), 32'd1);
                    end
                endcase
            end else begin
                tick();
            end
            n++;
        end
        if (n >= 500) begin
            checks++; failures++;
            $display("FAIL xfer_timeout actual=cmd_left:%0d,sdo_left:%0d expected=0", cmd_exp.size(), sdo_exp.size());
            cmd_exp.delete(); sdo_exp.delete();
        end
        chk("cmd_valid_drop", 32'(cmd_valid), 32'd0);
        chk("sdo_valid_drop", 32'(sdo_data_valid), 32'd0);
        chk("enabled_before_sync", 32'(ctrl_enabled), 32'd1);
        sync_valid = 1'b1;
        tick();
        sync_valid = 1'b0;
        m_dis = !ctrl_enable;
        chk("enabled_after_sync", 32'(ctrl_enabled), 32'(ctrl_enable));
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk(name, 32'(cmd_valid), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_enabled", 32'(ctrl_enabled), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_sdo_valid", 32'(sdo_data_valid), 32'd0);
        chk("sync_ready", 32'(sync_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Program load and first replay
        wr_cmd(16'h1001); wr_cmd(16'h2002); wr_cmd(16'h3003);
        wr_sdo(8'hA5); wr_sdo(8'h5A);
        set_en(1'b1);
        trig();
        run_xfer(0);

        // Repeat from index 0; trigger and sync during SEND must not disturb it
        trig();
        run_xfer(2);
        idle_check("no_replay", 6);

        // Backpressure with a random longer program
        set_en(1'b0);
        mem_rst(1'b0);
        for (int i = 0; i < 8; i++) wr_cmd(16'($urandom));
        for (int i = 0; i < 5; i++) wr_sdo(8'($urandom));
        set_en(1'b1);
        trig();
        run_xfer(1);

        // Disable mid-transfer; the writes issued then must not land
        trig();
        run_xfer(3);
        set_en(1'b1);
        trig();
        run_xfer(0);
        set_en(1'b0);

        // Saturation: 17 writes into 16 entries
        mem_rst(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) wr_cmd(16'(16'h0100 + i));
        for (int i = 0; i < DEPTH + 1; i++) wr_sdo(8'(8'h40 + i));
        set_en(1'b1);
        trig();
        run_xfer(0);
        set_en(1'b0);

        // Reset collides with a write: reset wins, then a fresh 3-word program
        mem_rst(1'b1);
        for (int i = 0; i < 3; i++) wr_cmd(16'($urandom));
        wr_sdo(8'($urandom));
        set_en(1'b1);
        trig();
        run_xfer(0);
        set_en(1'b0);

        // Empty program: trigger is ignored
        mem_rst(1'b0);
        set_en(1'b1);
        trig();
        idle_check("empty_no_cmd", 8);
        set_en(1'b0);

        // SDI pass-through
        for (int i = 0; i < 6; i++) begin
            sdi_data_valid    = 1'b1;
            sdi_data          = (i == 0) ? 8'h3C : 8'($urandom);
            offload_sdi_ready = i[0];
            #1;
            chk("sdi_ready_mirror", 32'(sdi_data_ready), 32'(offload_sdi_ready));
            chk("sdi_valid_pass", 32'(offload_sdi_valid), 32'd1);
            if (offload_sdi_ready) sdi_exp.push_back(sdi_data);
            tick();
        end
        sdi_data_valid = 1'b0; offload_sdi_ready = 1'b0;
        tick();
        chk("sdi_drained", 32'(sdi_exp.size()), 32'd0);

        // Reset during SEND
        for (int i = 0; i < 4; i++) wr_cmd(16'($urandom));
        set_en(1'b1);
        trig();
        rstn = 1'b0;
        tick();
        chk("rst_send_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_send_enabled", 32'(ctrl_enabled), 32'd0);
        rstn = 1'b1;
        cmd_exp.delete(); sdo_exp.delete();
        cmd_prog.delete(); sdo_prog.delete();
        m_dis = 1'b1;
        set_en(1'b1);
        trig();
        idle_check("rst_len_zero", 8);
        set_en(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
